// File: rtl/fd_hazard_ctrl_pkg.sv
// Shared types and constants for the fetch/decode sequencing controller.
package fd_hazard_ctrl_pkg;

  localparam int unsigned REG_W       = 3;
  localparam int unsigned DRAIN_DEPTH = 3;
  localparam int unsigned DRAIN_CNT_W = $clog2(DRAIN_DEPTH + 1);
  localparam int unsigned MISS_CNT_W  = 8;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    IMISS  = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } fd_state_e;

endpackage

// File: rtl/fd_hazard_detect.sv
// Combinational load-use comparator between the FD consumer and the DX load.
module fd_hazard_detect
  import fd_hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] dec_rs,
  input  logic [REG_W-1:0] dec_rt,
  input  logic             dec_uses_rs,
  input  logic             dec_uses_rt,
  input  logic [REG_W-1:0] dx_rd,
  input  logic             dx_valid,
  input  logic             dx_memread,
  output logic             load_use_c
);

  // Hazard only when a real load in DX writes a register FD is about to read.
  always_comb begin
    load_use_c = dx_valid & dx_memread &
                 ((dec_uses_rs & (dec_rs == dx_rd)) |
                  (dec_uses_rt & (dec_rt == dx_rd)));
  end

endmodule

// File: rtl/fd_hazard_ctrl.sv
// PC / FD sequencing controller: stalls, flushes, fetch-miss wait and halt drain.
module fd_hazard_ctrl
  import fd_hazard_ctrl_pkg::*;
#(
  parameter int unsigned IMISS_TIMEOUT = 64,
  parameter int unsigned STALL_CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [REG_W-1:0]       dec_rs,
  input  logic [REG_W-1:0]       dec_rt,
  input  logic                   dec_uses_rs,
  input  logic                   dec_uses_rt,
  input  logic                   dec_halt,
  input  logic [REG_W-1:0]       dx_rd,
  input  logic                   dx_valid,
  input  logic                   dx_memread,
  input  logic                   br_taken,
  input  logic                   imem_stall,
  input  logic                   imem_done,
  input  logic                   dmem_stall,
  output logic                   pc_we,
  output logic                   fd_we,
  output logic                   fd_valid_in,
  output logic                   dx_bubble,
  output logic                   halted,
  output logic                   err,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  localparam logic [MISS_CNT_W-1:0]  MISS_LIMIT = MISS_CNT_W'(IMISS_TIMEOUT);
  localparam logic [DRAIN_CNT_W-1:0] DRAIN_INIT = DRAIN_CNT_W'(DRAIN_DEPTH);

  fd_state_e              state_q, state_d;
  logic                   discard_q, discard_d;
  logic [DRAIN_CNT_W-1:0] drain_cnt_q, drain_cnt_d;
  logic [MISS_CNT_W-1:0]  miss_cnt_q, miss_cnt_d;
  logic                   err_q, err_set_c;
  logic [STALL_CNT_W-1:0] stall_q;
  logic                   load_use_c;
  logic                   pc_we_c, fd_we_c, fd_valid_c, dx_bubble_c;

  fd_hazard_detect u_detect (
    .dec_rs      (dec_rs),
    .dec_rt      (dec_rt),
    .dec_uses_rs (dec_uses_rs),
    .dec_uses_rt (dec_uses_rt),
    .dx_rd       (dx_rd),
    .dx_valid    (dx_valid),
    .dx_memread  (dx_memread),
    .load_use_c  (load_use_c)
  );

  // Next-state and pipe-control decode; dmem_stall freezes everything in every state.
  always_comb begin
    state_d     = state_q;
    discard_d   = discard_q;
    drain_cnt_d = drain_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    err_set_c   = 1'b0;
    pc_we_c     = 1'b0;
    fd_we_c     = 1'b0;
    fd_valid_c  = 1'b0;
    dx_bubble_c = 1'b0;

    unique case (state_q)
      RUN: begin
        if (dmem_stall) begin
          // full freeze
        end else if (br_taken) begin
          pc_we_c     = 1'b1;
          fd_we_c     = 1'b1;
          dx_bubble_c = 1'b1;
        end else if (load_use_c) begin
          dx_bubble_c = 1'b1;
        end else if (imem_stall) begin
          fd_we_c    = 1'b1;
          state_d    = IMISS;
          miss_cnt_d = MISS_CNT_W'(1);
        end else if (dec_halt) begin
          fd_we_c     = 1'b1;
          state_d     = DRAIN;
          drain_cnt_d = DRAIN_INIT;
        end else begin
          pc_we_c    = 1'b1;
          fd_we_c    = 1'b1;
          fd_valid_c = 1'b1;
        end
      end

      IMISS: begin
        if (miss_cnt_q < MISS_LIMIT) miss_cnt_d = miss_cnt_q + MISS_CNT_W'(1);
        if (dmem_stall) begin
          // full freeze, miss timer keeps running
        end else if (imem_done) begin
          // a same-cycle redirect makes the returning fetch stale
          pc_we_c     = 1'b1;
          fd_we_c     = 1'b1;
          fd_valid_c  = ~discard_q & ~br_taken;
          dx_bubble_c = br_taken;
          discard_d   = 1'b0;
          state_d     = RUN;
        end else if (br_taken) begin
          pc_we_c     = 1'b1;
          fd_we_c     = 1'b1;
          dx_bubble_c = 1'b1;
          discard_d   = 1'b1;
        end else begin
          fd_we_c = 1'b1;
        end
        err_set_c = (state_d == IMISS) && (miss_cnt_d == MISS_LIMIT);
      end

      DRAIN: begin
        if (dmem_stall) begin
          // full freeze, drain count holds
        end else if (br_taken) begin
          // HALT was fetched down a wrong path
          pc_we_c     = 1'b1;
          fd_we_c     = 1'b1;
          dx_bubble_c = 1'b1;
          drain_cnt_d = '0;
          state_d     = RUN;
        end else begin
          fd_we_c     = 1'b1;
          drain_cnt_d = drain_cnt_q - DRAIN_CNT_W'(1);
          if (drain_cnt_q <= DRAIN_CNT_W'(1)) state_d = HALTED;
        end
      end

      HALTED: begin
        dx_bubble_c = 1'b1;
      end

      default: begin
        state_d = RUN;
      end
    endcase
  end

  // State, counters and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      discard_q   <= 1'b0;
      drain_cnt_q <= '0;
      miss_cnt_q  <= '0;
      err_q       <= 1'b0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      discard_q   <= discard_d;
      drain_cnt_q <= drain_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      if (err_set_c) err_q <= 1'b1;
      if (!pc_we_c && (state_q != HALTED) && (stall_q != '1)) stall_q <= stall_q + STALL_CNT_W'(1);
    end
  end

  // Reset forces a safe bubble-injecting pipe regardless of state.
  always_comb begin
    pc_we        = ~rst & pc_we_c;
    fd_we        = ~rst & fd_we_c;
    fd_valid_in  = ~rst & fd_valid_c;
    dx_bubble    = rst | dx_bubble_c;
    halted       = ~rst & (state_q == HALTED);
    err          = err_q;
    stall_cycles = stall_q;
  end

endmodule
